// File: rtl/pipe_stage_buf.sv
// Elastic in-order buffer between pipeline stages with selective (age-based) squash and full flush.
// Latency 1 cycle (no bypass); in_ready depends on registered occupancy only.
module pipe_stage_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int ID_W  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [ID_W-1:0]            in_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [ID_W-1:0]            out_id,
  input  logic                       squash_valid,
  input  logic [ID_W-1:0]            squash_id,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [ID_W-1:0]  id_mem   [DEPTH];
  logic [PTR_W-1:0] head, tail, head_nxt, idx;
  logic [CNT_W-1:0] count_q, survive, survive_eff;
  logic             push, pop, alive, killed, sq_write, wr_en;

  function automatic logic [PTR_W-1:0] ptr_add(logic [PTR_W-1:0] p, logic [CNT_W-1:0] n);
    int unsigned s;
    s = 32'(p) + 32'(n);
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // a is younger than b when the modular distance a-b is nonzero and in the lower half
  function automatic logic younger(logic [ID_W-1:0] a, logic [ID_W-1:0] b);
    logic [ID_W-1:0] d;
    d = a - b;
    return (d != '0) && !d[ID_W-1];
  endfunction

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = data_mem[head];
  assign out_id    = id_mem[head];
  assign count     = count_q;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign head_nxt = pop ? ptr_add(head, CNT_W'(1)) : head;

  // Survivors of a squash are the leading run of entries not younger than squash_id.
  always_comb begin
    survive = '0;
    alive   = 1'b1;
    idx     = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = ptr_add(head, CNT_W'(i));
      if (alive && (CNT_W'(i) < count_q) && !younger(id_mem[idx], squash_id))
        survive = survive + CNT_W'(1);
      else
        alive = 1'b0;
    end
  end

  // A popped head leaves regardless of age, so it is treated as a survivor.
  assign survive_eff = (pop && survive == '0) ? CNT_W'(1) : survive;
  assign killed      = (survive_eff != count_q);
  assign sq_write    = push && !killed && !younger(in_id, squash_id);
  assign wr_en       = rstn && !flush && (squash_valid ? sq_write : push);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head <= head_nxt;
      if (flush) begin
        tail    <= head_nxt;
        count_q <= '0;
      end else if (squash_valid) begin
        count_q <= survive_eff - CNT_W'(pop) + CNT_W'(sq_write);
        tail    <= ptr_add(head, survive_eff + CNT_W'(sq_write));
      end else begin
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) tail <= ptr_add(tail, CNT_W'(1));
      end
    end
  end

  // A surviving squash-cycle push implies nothing was killed, so tail is still valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[tail] <= in_data;
      id_mem[tail]   <= in_id;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: directed scenarios followed by randomized traffic.
module tb_pipe_stage_buf;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0, squash_valid = 1'b0, flush = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [IW-1:0] in_id = '0, squash_id = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_id;
  logic [2:0]    count;

  pipe_stage_buf #(.WIDTH(W), .DEPTH(D), .ID_W(IW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .squash_valid(squash_valid), .squash_id(squash_id), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } ent_t;

  ent_t          exp_q[$];
  int            tests = 0, fails = 0;
  int            pre_size = 0;
  bit            chk_en = 1'b0;
  bit            last_push = 1'b0;
  logic [IW-1:0] next_id = '0;

  function automatic bit is_younger(logic [IW-1:0] a, logic [IW-1:0] b);
    int d;
    d = (int'(a) - int'(b) + 256) % 256;
    return (d != 0) && (d < 128);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares visible state against the expected queue and consumes delivered entries.
  always @(negedge clk) begin
    pre_size = exp_q.size();
    if (chk_en) begin
      check("out_valid", {63'd0, out_valid}, {63'd0, pre_size != 0});
      check("in_ready", {63'd0, in_ready}, {63'd0, pre_size != D});
      check("count", {61'd0, count}, 64'(pre_size));
      if (pre_size != 0 && out_ready) begin
        check("out_id", {56'd0, out_id}, {56'd0, exp_q[0].id});
        check("out_data", {32'd0, out_data}, {32'd0, exp_q[0].data});
        void'(exp_q.pop_front());
      end
    end
  end

  // Reference model: queue of in-flight entries in program order.
  always @(posedge clk) begin
    bit acc, kill;
    int keep;
    last_push = 1'b0;
    if (!rstn) begin
      exp_q.delete();
    end else begin
      acc = in_valid && (pre_size != D);
      last_push = acc;
      if (flush) begin
        exp_q.delete();
      end else if (squash_valid) begin
        keep = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++)
          if (is_younger(exp_q[i].id, squash_id)) begin
            keep = i;
            break;
          end
        kill = (keep != exp_q.size());
        while (exp_q.size() > keep) void'(exp_q.pop_back());
        if (acc && !kill && !is_younger(in_id, squash_id))
          exp_q.push_back('{id: in_id, data: in_data});
      end else if (acc) begin
        exp_q.push_back('{id: in_id, data: in_data});
      end
    end
  end

  task automatic cyc(input bit iv, input bit ordy, input bit sqv, input logic [IW-1:0] sqid, input bit fl);
    in_valid     = iv;
    in_id        = next_id;
    in_data      = $urandom;
    out_ready    = ordy;
    squash_valid = sqv;
    squash_id    = sqid;
    flush        = fl;
    @(posedge clk);
    #1;
    if (last_push) next_id = next_id + 8'd1;
  endtask

  task automatic push_n(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    repeat (6) cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("drained", {61'd0, count}, 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rstn = 1'b1;

    // Back-to-back streaming
    next_id = 8'd1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
      check("stream_count", {61'd0, count}, 64'd1);
    end
    drain();

    // Fill to full, stall, then one pop frees a slot for the next cycle
    next_id = 8'd20;
    push_n(4);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_count", {61'd0, count}, 64'd4);
    push_n(1);
    check("stall_count", {61'd0, count}, 64'd4);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("pop_at_full_count", {61'd0, count}, 64'd3);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("late_accept_count", {61'd0, count}, 64'd4);
    check("late_accept_next_id", {56'd0, next_id}, 64'd25);
    drain();

    // Selective squash keeps the squashing id
    next_id = 8'd10;
    push_n(4);
    cyc(1'b0, 1'b0, 1'b1, 8'd11, 1'b0);
    check("squash_count", {61'd0, count}, 64'd2);
    check("squash_in_ready", {63'd0, in_ready}, 64'd1);
    drain();

    // Squash across id wraparound, concurrent push dropped
    next_id = 8'd254;
    push_n(4);
    cyc(1'b1, 1'b0, 1'b1, 8'd255, 1'b0);
    check("wrap_squash_count", {61'd0, count}, 64'd2);
    drain();

    // Pop + push + squash in one cycle
    next_id = 8'd12;
    push_n(2);
    cyc(1'b1, 1'b1, 1'b1, 8'd12, 1'b0);
    check("pps_count", {61'd0, count}, 64'd0);
    check("pps_out_valid", {63'd0, out_valid}, 64'd0);
    drain();

    // Flush with concurrent push
    next_id = 8'd30;
    push_n(3);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("flush_count", {61'd0, count}, 64'd0);
    drain();

    // Reset mid-stream
    next_id = 8'd40;
    push_n(2);
    rstn = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("midrst_count", {61'd0, count}, 64'd0);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    rstn = 1'b1;
    next_id = 8'd5;
    push_n(1);
    check("postrst_out_valid", {63'd0, out_valid}, 64'd1);
    check("postrst_out_id", {56'd0, out_id}, 64'd5);
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rstn = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0, next_id - 8'($urandom_range(1, 6)),
          $urandom_range(0, 49) == 0);
    end
    rstn = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
